// File: rtl/serializador_acumulador.sv
// Captures {overflow, accumulated value} samples into a small FIFO and ships each one
// as a 10-bit serial frame: start, d[0]..d[5], ovf, even parity, stop.
module serializador_acumulador #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV        = 4
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_data,
  input  logic       i_overflow,
  input  logic       i_capture,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_full,
  output logic       o_drop
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t         r_state, w_state_n;
  logic [6:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [AW:0]    r_count, w_count_n;
  logic [8:0]     r_frame, w_frame_n;
  logic [3:0]     r_bit, w_bit_n;
  logic [DW-1:0]  r_div, w_div_n;
  logic           r_tx, w_tx_n, r_busy, w_busy_n, r_full, r_drop;
  logic           w_full, w_empty, w_push, w_pop, w_load;
  logic [6:0]     w_head;

  // Fullness comes from the registered count, so a pop at the same edge cannot make room.
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_capture && !w_full;
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {i_overflow, i_data};
  end

  always_comb begin
    w_count_n = r_count;
    if (w_push && !w_pop)      w_count_n = r_count + (AW+1)'(1);
    else if (!w_push && w_pop) w_count_n = r_count - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_n;
      r_full  <= (w_count_n == (AW+1)'(FIFO_DEPTH));
      r_drop  <= i_capture && w_full;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_frame <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_frame <= w_frame_n;
      r_bit   <= w_bit_n;
      r_div   <= w_div_n;
      r_tx    <= w_tx_n;
      r_busy  <= w_busy_n;
    end
  end

  // r_frame holds the bits after the start bit: {stop, parity, ovf, d[5:0]}.
  always_comb begin
    w_state_n = r_state;
    w_frame_n = r_frame;
    w_bit_n   = r_bit;
    w_div_n   = r_div;
    w_tx_n    = r_tx;
    w_busy_n  = r_busy;
    w_load    = 1'b0;
    case (r_state)
      S_IDLE: w_load = !w_empty;
      S_SEND: begin
        if (r_div == DW'(DIV - 1)) begin
          w_div_n = '0;
          if (r_bit == 4'd9) begin
            if (!w_empty) begin
              w_load = 1'b1;
            end else begin
              w_state_n = S_IDLE;
              w_tx_n    = 1'b1;
              w_busy_n  = 1'b0;
            end
          end else begin
            w_bit_n = r_bit + 4'd1;
            w_tx_n  = r_frame[r_bit];
          end
        end else begin
          w_div_n = r_div + DW'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_load) begin
      w_state_n = S_SEND;
      w_frame_n = {1'b1, ^w_head, w_head};
      w_bit_n   = '0;
      w_div_n   = '0;
      w_tx_n    = 1'b0;
      w_busy_n  = 1'b1;
    end
    w_pop = w_load;
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;
  assign o_full = r_full;
  assign o_drop = r_drop;
endmodule

// File: doc/serializador_acumulador.md
# serializador_acumulador

Downstream stage of the selective-adder/accumulator datapath. It captures the 6-bit accumulated value and its overflow flag on request and buffers the samples in a small FIFO. Each sample is shipped out on a single serial line as a 10-bit framed word: start bit, 6 data bits, overflow bit, even parity, stop bit. It turns the accumulator's parallel output into something observable on one pin.

## Interface
- `FIFO_DEPTH`, default 4: sample buffer entries; power of two, ≥2.
- `DIV`, default 4: clock cycles per serial bit; ≥1.
- `clk` in 1: single clock, rising edge.
- `i_rst_n` in 1: reset; asynchronous, active-low.
- `i_data` in 6: accumulated value from the accumulator stage.
- `i_overflow` in 1: overflow flag from the accumulator stage.
- `i_capture` in 1: capture request, sampled each rising edge; one sample per high cycle.
- `o_tx` out 1: serial line; idles high.
- `o_busy` out 1: high while a frame is on the line.
- `o_full` out 1: FIFO holds `FIFO_DEPTH` samples.
- `o_drop` out 1: one-cycle pulse, a capture was rejected.

## Operation
- Reset (async assert): FIFO emptied, FSM→IDLE, bit/div counters 0; `o_tx`=1, `o_busy`=0, `o_full`=0, `o_drop`=0. All outputs are registered.
- Capture: at an edge with `i_capture`=1 and `o_full`=0, {`i_overflow`,`i_data`} is written to the FIFO.
  - With `o_full`=1 the sample is discarded and `o_drop`=1 for the next cycle.
  - Fullness is evaluated from the registered count. A capture at the same edge as a pop from a full FIFO is still dropped.
- Frame, in transmission order: start 0, `d[0]`..`d[5]` (LSB first), `ovf`, parity `p`, stop 1.
  - Parity: `p` = XOR of `d[5:0]` and `ovf`, so the 8 payload bits plus `p` have an even number of ones.
- FSM states:
  - IDLE: `o_tx`=1, `o_busy`=0. On an edge with FIFO non-empty, pop the head, load the shift register, go to SEND, and drive `o_tx`=0 (start bit).
  - SEND: each bit is held exactly `DIV` cycles, then the bit index advances 0..9.
- End of stop bit (last of its `DIV` cycles):
  - FIFO non-empty: pop and begin the next start bit at that edge, with no idle gap. `o_busy` stays 1.
  - FIFO empty: go to IDLE, `o_busy`=0.
- Capture and pop at the same edge with the FIFO not full: both happen, and the count is unchanged.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Count ranges 0..`FIFO_DEPTH`.
- Reset mid-frame: `o_tx` goes to 1 immediately, the frame is abandoned, and buffered samples are lost.
- `i_data`/`i_overflow` are only sampled on capture. Changes at other times have no effect.

## Timing
- Capture sampled at edge T with FSM in IDLE and FIFO empty:
  - Count becomes 1 after T.
  - Pop and start bit are driven from edge T+1.
  - `o_busy` rises at T+1.
- Frame length is 10·`DIV` cycles; 40 cycles at defaults.
- Bit k occupies cycles [T+1+k·`DIV`, T+1+(k+1)·`DIV`).
- `o_drop` is asserted in the cycle after the rejected capture edge, for 1 cycle.
- `o_full` updates the cycle after the write or pop that changes the count.
- Throughput: one frame per 10·`DIV` cycles. Sustained capture faster than this fills the FIFO and then drops.

## Test plan
Defaults `DIV`=4 and `FIFO_DEPTH`=4 unless noted.
- Reset:
  - Stimulus: hold `i_rst_n`=0, toggle `i_capture`, release.
  - Required: `o_tx`=1, `o_busy`=0, `o_full`=0, `o_drop`=0 throughout. No frame after release.
- Single frame:
  - Stimulus: `i_data`=6'h2D, `i_overflow`=0, one-cycle capture at edge T.
  - Required: from T+1, `o_tx` = 0,1,0,1,1,0,1,0,0,1, each bit for 4 cycles. `o_busy` high for exactly 40 cycles.
- Odd parity case:
  - Stimulus: `i_data`=6'h3F, `i_overflow`=1.
  - Required: data bits all 1, ovf=1, parity=1, stop=1.
- Overflow of buffer:
  - Stimulus: one capture; then, during that frame, 5 captures on consecutive cycles (values 1..5).
  - Required: values 1–4 accepted and `o_full`=1 after the 4th. Value 5 is dropped with a single `o_drop` pulse.
  - Required: 5 frames (first, 1, 2, 3, 4) transmitted back-to-back, with `o_busy` continuously high for 200 cycles.
- Capture at pop edge while full:
  - Stimulus: FIFO full, `i_capture`=1 exactly at a stop-bit-end edge.
  - Required: sample dropped, `o_drop` pulses, count goes 4→3.
- Reset mid-frame:
  - Stimulus: assert `i_rst_n`=0 during bit 3 with 2 samples queued.
  - Required: `o_tx`=1 and `o_busy`=0 asynchronously. After release, no frames; `o_full`=0.
